// File: rtl/rtc_spi_streamer.sv
// Real-time clock (binary or packed-BCD h:m:s) with a 1 s prescaler; after each tick the
// time is streamed as a 24-bit SPI mode-0 frame while 24 bits are captured from miso.
module rtc_spi_streamer #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int SCLK_DIV = 4,
  parameter bit BCD      = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_valid,
  input  logic [7:0]  set_hours,
  input  logic [7:0]  set_minutes,
  input  logic [7:0]  set_seconds,
  output logic [7:0]  hours,
  output logic [7:0]  minutes,
  output logic [7:0]  seconds,
  output logic        tick_1s,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n,
  output logic        busy,
  output logic [23:0] rx_frame,
  output logic        rx_valid
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_TC = DW'(SCLK_DIV - 1);
  localparam logic [7:0] HOUR_MAX = BCD ? 8'h23 : 8'd23;
  localparam logic [7:0] MS_MAX   = BCD ? 8'h59 : 8'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [PW-1:0]  pre_cnt;
  logic           pre_tc;
  logic [DW-1:0]  div_cnt;
  logic           div_tc;
  logic [4:0]     bit_cnt;
  logic [23:0]    tx_sr;
  logic [23:0]    rx_sr;
  logic           start;
  logic           rise;
  logic           fall;
  logic           done;

  function automatic logic [7:0] field_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == max_v) begin
      r = 8'd0;
    end else if (BCD && (v[3:0] == 4'd9)) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Whole-byte compare against max is valid for BCD too once both nibbles are <= 9.
  function automatic logic [7:0] field_load(input logic [7:0] v, input logic [7:0] max_v);
    logic ok;
    ok = (v <= max_v);
    if (BCD && ((v[7:4] > 4'd9) || (v[3:0] > 4'd9))) begin
      ok = 1'b0;
    end
    return ok ? v : 8'd0;
  endfunction

  assign pre_tc = (pre_cnt == PRE_TC);
  assign div_tc = (div_cnt == DIV_TC);

  // The load cycle itself counts as prescaler count 0, so the next tick lands CLK_DIV
  // cycles after the cycle carrying set_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      tick_1s <= 1'b0;
    end else begin
      tick_1s <= pre_tc & ~set_valid;
      if (set_valid) begin
        pre_cnt <= PW'(1);
      end else if (pre_tc) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hours   <= 8'd0;
      minutes <= 8'd0;
      seconds <= 8'd0;
    end else if (set_valid) begin
      hours   <= field_load(set_hours, HOUR_MAX);
      minutes <= field_load(set_minutes, MS_MAX);
      seconds <= field_load(set_seconds, MS_MAX);
    end else if (pre_tc) begin
      seconds <= field_inc(seconds, MS_MAX);
      if (seconds == MS_MAX) begin
        minutes <= field_inc(minutes, MS_MAX);
        if (minutes == MS_MAX) begin
          hours <= field_inc(hours, HOUR_MAX);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    rise    = 1'b0;
    fall    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_1s) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (div_tc) begin
          if (sclk) begin
            fall = 1'b1;
            if (bit_cnt == 5'd23) begin
              state_d = HOLD;
            end
          end else begin
            rise = 1'b1;
          end
        end
      end
      HOLD: begin
        if (div_tc) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      bit_cnt  <= 5'd0;
      tx_sr    <= 24'd0;
      rx_sr    <= 24'd0;
      sclk     <= 1'b0;
      ss_n     <= 1'b1;
      rx_frame <= 24'd0;
      rx_valid <= 1'b0;
    end else begin
      ss_n     <= (state_d == IDLE);
      rx_valid <= done;
      if (start) begin
        tx_sr   <= {hours, minutes, seconds};
        div_cnt <= '0;
        bit_cnt <= 5'd0;
        sclk    <= 1'b0;
      end else if (state_q != IDLE) begin
        div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      end
      if (rise) begin
        sclk  <= 1'b1;
        rx_sr <= {rx_sr[22:0], miso};
      end
      // The last falling edge leaves mosi on bit 0 until the next frame.
      if (fall) begin
        sclk    <= 1'b0;
        bit_cnt <= bit_cnt + 5'd1;
        if (state_d == SHIFT) begin
          tx_sr <= {tx_sr[22:0], 1'b0};
        end
      end
      if (done) begin
        rx_frame <= rx_sr;
      end
    end
  end

  assign mosi = tx_sr[23];
  assign busy = ~ss_n;

endmodule

// File: tb/tb_rtc_spi_streamer.sv
// Directed + randomized bench: a binary and a BCD instance checked against a seconds-of-day model.
module tb_rtc_spi_streamer;

  localparam int CD = 200;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_valid_a, set_valid_b;
  logic [23:0] set_a, set_b;
  logic        miso_a, miso_b;
  logic [7:0]  hours_a, minutes_a, seconds_a, hours_b, minutes_b, seconds_b;
  logic        tick_a, sclk_a, mosi_a, ss_n_a, busy_a, rx_valid_a;
  logic        tick_b, sclk_b, mosi_b, ss_n_b, busy_b, rx_valid_b;
  logic [23:0] rx_frame_a, rx_frame_b;

  int cyc = 0;
  int total = 0;
  int fails = 0;
  int tod_a = 0;
  int tod_b = 0;
  int exp_tick;
  int last_load;
  int when;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_spi_streamer #(.CLK_DIV(CD), .SCLK_DIV(SD), .BCD(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .set_valid(set_valid_a),
    .set_hours(set_a[23:16]), .set_minutes(set_a[15:8]), .set_seconds(set_a[7:0]),
    .hours(hours_a), .minutes(minutes_a), .seconds(seconds_a), .tick_1s(tick_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss_n(ss_n_a), .busy(busy_a),
    .rx_frame(rx_frame_a), .rx_valid(rx_valid_a)
  );

  rtc_spi_streamer #(.CLK_DIV(CD), .SCLK_DIV(SD), .BCD(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .set_valid(set_valid_b),
    .set_hours(set_b[23:16]), .set_minutes(set_b[15:8]), .set_seconds(set_b[7:0]),
    .hours(hours_b), .minutes(minutes_b), .seconds(seconds_b), .tick_1s(tick_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss_n(ss_n_b), .busy(busy_b),
    .rx_frame(rx_frame_b), .rx_valid(rx_valid_b)
  );

  function automatic logic [7:0] enc(input int n, input bit bcd);
    return bcd ? 8'((n / 10) * 16 + (n % 10)) : 8'(n);
  endfunction

  function automatic logic [23:0] frame_of(input int tod, input bit bcd);
    return {enc(tod / 3600, bcd), enc((tod / 60) % 60, bcd), enc(tod % 60, bcd)};
  endfunction

  function automatic int dec(input logic [7:0] v, input int max_n, input bit bcd);
    int n;
    int hi;
    int lo;
    hi = int'(v) / 16;
    lo = int'(v) % 16;
    if (bcd) begin
      if (hi > 9 || lo > 9) return 0;
      n = hi * 10 + lo;
    end else begin
      n = int'(v);
    end
    return (n > max_n) ? 0 : n;
  endfunction

  function automatic int tod_of(input logic [23:0] v, input bit bcd);
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    h = v[23:16];
    m = v[15:8];
    s = v[7:0];
    return dec(h, 23, bcd) * 3600 + dec(m, 59, bcd) * 60 + dec(s, 59, bcd);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input bit sel, input int budget, output int at);
    int i;
    at = -1;
    i = 0;
    while (at < 0 && i < budget) begin
      @(negedge clk);
      i++;
      if (sel ? tick_b : tick_a) at = cyc;
    end
    chk("tick_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic do_load(input bit sel, input logic [23:0] v);
    @(negedge clk);
    if (sel) begin set_b = v; set_valid_b = 1'b1; end
    else     begin set_a = v; set_valid_a = 1'b1; end
    @(negedge clk);
    set_valid_a = 1'b0;
    set_valid_b = 1'b0;
    last_load = cyc;
    if (sel) begin
      tod_b = tod_of(v, 1'b1);
      chk("load_time_b", 32'({hours_b, minutes_b, seconds_b}), 32'(frame_of(tod_b, 1'b1)));
    end else begin
      tod_a = tod_of(v, 1'b0);
      chk("load_time_a", 32'({hours_a, minutes_a, seconds_a}), 32'(frame_of(tod_a, 1'b0)));
    end
  endtask

  task automatic tick_a_step();
    wait_tick(1'b0, 2 * CD, when);
    chk("tick_cycle", 32'(when), 32'(exp_tick));
    tod_a = (tod_a + 1) % 86400;
    chk("time_on_tick", 32'({hours_a, minutes_a, seconds_a}), 32'(frame_of(tod_a, 1'b0)));
    exp_tick = when + CD;
  endtask

  // Called in the tick cycle; observes one full frame of dut_a.
  task automatic run_frame(input logic [23:0] exp, input bit loop, input int load_at,
                           input logic [23:0] load_v);
    logic [23:0] tx;
    logic [23:0] rx;
    int rises;
    int low;
    int vcount;
    bit vok;
    logic prev_sclk;
    logic prev_ss;
    logic drv;
    tx = '0; rx = '0; rises = 0; low = 0; vcount = 0; vok = 1'b1;
    prev_sclk = 1'b0; prev_ss = 1'b1; drv = miso_a;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 0) chk("tick_one_cycle", 32'(tick_a), 32'd0);
      if (i == load_at) begin
        set_a = load_v;
        set_valid_a = 1'b1;
      end
      if (load_at >= 0 && i == load_at + 1) begin
        set_valid_a = 1'b0;
        last_load = cyc;
        tod_a = tod_of(load_v, 1'b0);
        chk("midframe_load_time", 32'({hours_a, minutes_a, seconds_a}), 32'(frame_of(tod_a, 1'b0)));
      end
      if (!prev_sclk && sclk_a) begin
        tx = {tx[22:0], mosi_a};
        rx = {rx[22:0], drv};
        rises++;
      end
      if (!ss_n_a) low++;
      if (rx_valid_a) begin
        vcount++;
        if (!(prev_ss == 1'b0 && ss_n_a == 1'b1)) vok = 1'b0;
      end
      if (busy_a !== ~ss_n_a) vok = 1'b0;
      prev_sclk = sclk_a;
      prev_ss = ss_n_a;
      drv = loop ? mosi_a : 1'($urandom_range(0, 1));
      miso_a = drv;
    end
    chk("sclk_rises", 32'(rises), 32'd24);
    chk("ss_low_cycles", 32'(low), 32'(49 * SD));
    chk("mosi_frame", 32'(tx), 32'(exp));
    chk("rx_valid_count", 32'(vcount), 32'd1);
    chk("rx_valid_align_busy", 32'(vok), 32'd1);
    chk("rx_frame", 32'(rx_frame_a), 32'(rx));
  endtask

  initial begin
    int ss_cnt;
    int tk_cnt;
    logic [23:0] v;
    reset_n = 1'b0;
    set_valid_a = 1'b0; set_valid_b = 1'b0;
    set_a = '0; set_b = '0; miso_a = 1'b0; miso_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_time", 32'({hours_a, minutes_a, seconds_a}), 32'd0);
    chk("rst_tick", 32'(tick_a), 32'd0);
    chk("rst_sclk", 32'(sclk_a), 32'd0);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    chk("rst_ss_n", 32'(ss_n_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_rx_frame", 32'(rx_frame_a), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    reset_n = 1'b1;
    exp_tick = cyc + CD;

    // Three free-running ticks from reset.
    for (int k = 0; k < 3; k++) begin
      tick_a_step();
      run_frame(frame_of(tod_a, 1'b0), 1'b0, -1, '0);
    end
    chk("seconds_after_3", 32'(seconds_a), 32'd3);

    // Midnight rollover.
    do_load(1'b0, {8'd23, 8'd59, 8'd59});
    exp_tick = last_load + CD - 1;
    tick_a_step();
    run_frame(frame_of(tod_a, 1'b0), 1'b0, -1, '0);

    // Load in the same cycle as the prescaler terminal count drops that tick.
    while (cyc < exp_tick - 1) @(negedge clk);
    set_a = {8'd12, 8'd34, 8'd56};
    set_valid_a = 1'b1;
    @(negedge clk);
    set_valid_a = 1'b0;
    last_load = cyc;
    tod_a = tod_of(set_a, 1'b0);
    chk("load_beats_tick", 32'(tick_a), 32'd0);
    chk("load_at_tick_time", 32'({hours_a, minutes_a, seconds_a}), 32'h0c2238);
    ss_cnt = 0; tk_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (!ss_n_a) ss_cnt++;
      if (tick_a) tk_cnt++;
    end
    chk("no_frame_after_drop", 32'(ss_cnt), 32'd0);
    chk("no_tick_after_drop", 32'(tk_cnt), 32'd0);
    exp_tick = last_load + CD - 1;
    tick_a_step();
    run_frame(frame_of(tod_a, 1'b0), 1'b0, -1, '0);

    // Loopback: rx_frame must echo the transmitted frame.
    tick_a_step();
    run_frame(frame_of(tod_a, 1'b0), 1'b1, -1, '0);
    chk("loopback_rx", 32'(rx_frame_a), 32'(frame_of(tod_a, 1'b0)));

    // Load mid-frame: frame keeps its snapshot.
    tick_a_step();
    run_frame(frame_of(tod_a, 1'b0), 1'b0, 40, {8'd1, 8'd2, 8'd3});
    exp_tick = last_load + CD - 1;

    // Random loads, some out of range.
    for (int k = 0; k < 4; k++) begin
      v = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 63)), 8'($urandom_range(0, 63))};
      do_load(1'b0, v);
      exp_tick = last_load + CD - 1;
      tick_a_step();
      run_frame(frame_of(tod_a, 1'b0), 1'b0, -1, '0);
    end

    // Asynchronous reset in the middle of a frame.
    tick_a_step();
    repeat (30) @(negedge clk);
    chk("busy_before_reset", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_ss_n", 32'(ss_n_a), 32'd1);
    chk("arst_sclk", 32'(sclk_a), 32'd0);
    chk("arst_time", 32'({hours_a, minutes_a, seconds_a}), 32'd0);
    chk("arst_rx_frame", 32'(rx_frame_a), 32'd0);
    repeat (3) @(negedge clk);
    chk("held_reset_ss_n", 32'(ss_n_a), 32'd1);
    reset_n = 1'b1;
    tod_a = 0;
    exp_tick = cyc + CD;
    tick_a_step();
    run_frame(frame_of(tod_a, 1'b0), 1'b0, -1, '0);

    // BCD instance.
    do_load(1'b1, 24'h095959);
    wait_tick(1'b1, 2 * CD, when);
    chk("bcd_tick_cycle", 32'(when), 32'(last_load + CD - 1));
    tod_b = (tod_b + 1) % 86400;
    chk("bcd_carry", 32'({hours_b, minutes_b, seconds_b}), 32'(frame_of(tod_b, 1'b1)));
    do_load(1'b1, 24'h1A6005);
    chk("bcd_bad_load", 32'({hours_b, minutes_b, seconds_b}), 32'h000005);
    do_load(1'b1, 24'h235959);
    wait_tick(1'b1, 2 * CD, when);
    tod_b = (tod_b + 1) % 86400;
    chk("bcd_midnight", 32'({hours_b, minutes_b, seconds_b}), 32'(frame_of(tod_b, 1'b1)));
    for (int k = 0; k < 3; k++) begin
      v[23:16] = ($urandom_range(0, 1) != 0) ? enc(int'($urandom_range(0, 23)), 1'b1) : 8'($urandom);
      v[15:8]  = ($urandom_range(0, 1) != 0) ? enc(int'($urandom_range(0, 59)), 1'b1) : 8'($urandom);
      v[7:0]   = ($urandom_range(0, 1) != 0) ? enc(int'($urandom_range(0, 59)), 1'b1) : 8'($urandom);
      do_load(1'b1, v);
      wait_tick(1'b1, 2 * CD, when);
      tod_b = (tod_b + 1) % 86400;
      chk("bcd_random_tick", 32'({hours_b, minutes_b, seconds_b}), 32'(frame_of(tod_b, 1'b1)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/rtc_spi_streamer.md
# rtc_spi_streamer

Parametrised real-time clock with an integrated SPI master. It derives a one-second tick from the system clock, keeps hours/minutes/seconds in binary or BCD, and accepts a synchronous time load. After every tick it streams a 24-bit time frame over SPI mode 0 and captures 24 bits from MISO. It replaces the free-standing 1 Hz-clocked RTC and the testbench-style SPI sender with one synthesizable block on the system clock.

## Interface
- `CLK_DIV`, default 50_000_000: `clk` cycles per second tick. Must be ≥ 49*`SCLK_DIV` + 4.
- `SCLK_DIV`, default 4: `clk` cycles per SCLK half-period. Must be ≥ 1.
- `BCD`, default 0: field encoding. 0 selects binary, 1 selects packed BCD. Applies to set inputs, time outputs and the SPI frame.
- `clk` in 1: system clock. One clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `set_valid` in 1: single-cycle strobe that loads the `set_*` fields.
- `set_hours` / `set_minutes` / `set_seconds` in 8 each: load values.
- `hours` / `minutes` / `seconds` out 8 each: current time.
- `tick_1s` out 1: one-cycle pulse on each second boundary.
- `sclk` out 1: SPI clock. Idles low.
- `mosi` out 1: SPI data out, MSB first.
- `miso` in 1: SPI data in.
- `ss_n` out 1: slave select, active low.
- `busy` out 1: high while a frame is in progress. Equals `~ss_n`.
- `rx_frame` out 24: last captured MISO frame.
- `rx_valid` out 1: one-cycle pulse when `rx_frame` updates.

## Operation
- **Reset values:** all time fields 0, prescaler 0, `tick_1s` 0, `sclk` 0, `mosi` 0, `ss_n` 1, `busy` 0, `rx_frame` 0, `rx_valid` 0. Reset is asynchronous and aborts any frame immediately.
- **Prescaler:** counts 0..`CLK_DIV`-1. `tick_1s` is registered high for the one cycle after the count equals `CLK_DIV`-1, and the count wraps to 0.
- **Time update on tick:**
  - seconds increments.
  - At 59, seconds goes to 0 and minutes increments.
  - At minutes 59, minutes goes to 0 and hours increments.
  - At hours 23, hours goes to 0.
  - In BCD mode the low nibble carries 9→0 into the high nibble, and the wrap points are 0x59 and 0x23.
- **Load:** `set_valid` loads all three fields and clears the prescaler to 0. A load beats a tick in the same cycle; that tick is dropped and no frame starts.
- **Out-of-range loads:** hours > 23, minutes/seconds > 59, or any BCD nibble > 9 loads that field as 0. Other fields load normally.
- **Frame contents:** {hours, minutes, seconds}. Bit 23 is sent first.
- **Frame start:** in the cycle `tick_1s` is high, the updated time is snapshotted into the TX shift register. A load during a frame does not alter that frame.
- **SPI FSM states:**
  - IDLE: `ss_n`=1, `sclk`=0. On tick, go to SHIFT.
  - SHIFT: `ss_n`=0. `sclk` toggles every `SCLK_DIV` cycles. `miso` is sampled into the RX shift register on each rising edge. `mosi` advances on each falling edge. After 24 falling edges, go to HOLD.
  - HOLD: `sclk`=0 for `SCLK_DIV` cycles. Then `ss_n` goes to 1, `rx_frame` is updated, `rx_valid` pulses, and the FSM returns to IDLE.
- **Mode 0:** `mosi` is stable while `sclk` is low and valid before each rising edge.
- **Overlap:** the parameter rule guarantees a frame finishes before the next tick, so no queueing is needed.

## Timing
- Time outputs change in the cycle `tick_1s` is asserted, i.e. one cycle after the prescaler terminal count.
- Let T0 be the cycle after `tick_1s`:
  - T0: `ss_n` falls and `mosi` = bit 23.
  - Rising edge k (k = 1..24) at T0 + (2k-1)*`SCLK_DIV`.
  - Falling edge k at T0 + 2k*`SCLK_DIV`.
  - `ss_n` rises at T0 + 49*`SCLK_DIV`, in the same cycle as the `rx_valid` pulse.
- With `SCLK_DIV`=4, `ss_n` is low for 196 cycles.
- After `set_valid` in cycle S, the time outputs show the loaded values at S+1. The next tick occurs at S+`CLK_DIV`.
- After the frame, `mosi` holds the last bit until the next frame start.

## Test plan
1. `CLK_DIV`=200, `SCLK_DIV`=2, `BCD`=0; release reset and run 3 ticks -> `seconds`=3, tick spacing is 200 cycles, and the third frame on `mosi` is 0x000003 with `ss_n` low for 98 cycles.
2. Load 23:59:59 binary, then one tick -> time 00:00:00 and frame 0x000000. Load 12:34:56 in the same cycle as a tick -> time 12:34:56, no frame, next tick 200 cycles later.
3. `BCD`=1: load 0x09:0x59:0x59, then one tick -> 0x10:0x00:0x00. Load 0x1A:0x60:0x05 -> 0x00:0x00:0x05.
4. Tie `miso` to `mosi` -> after each frame `rx_frame` equals the transmitted frame, and `rx_valid` is one cycle, coincident with `ss_n` rising.
5. `set_valid` with 01:02:03 issued mid-frame -> the current frame still carries the pre-load snapshot; time outputs show 01:02:03 the next cycle.
6. Assert `reset_n` low mid-frame -> `ss_n`=1, `sclk`=0, time=0 and `rx_frame`=0 immediately (asynchronous); the first frame after release follows the first tick.
